// File: rtl/regs_wb_arbiter.sv
`default_nettype none
// ============================================================================
// regs_wb_arbiter : two-port (EX / LSU) register-file write-back arbiter
// Revision 1.0
// ============================================================================
module regs_wb_arbiter #(
   parameter int STARVE_LIMIT = 3
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        ex_valid_i,
   input  logic [4:0]  ex_waddr_i,
   input  logic [31:0] ex_wdata_i,
   output logic        ex_ready_o,
   input  logic        lsu_valid_i,
   input  logic [4:0]  lsu_waddr_i,
   input  logic [31:0] lsu_wdata_i,
   output logic        lsu_ready_o,
   output logic [4:0]  reg_waddr_o,
   output logic [31:0] reg_wdata_o,
   output logic        reg_wen_o,
   output logic        starve_o
);

   localparam int CNT_W = $clog2(STARVE_LIMIT + 1);
   localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(STARVE_LIMIT);

   logic [CNT_W-1:0] starve_cnt;
   logic             starved;
   logic [4:0]       win_addr;
   logic [31:0]      win_data;
   logic             any_xfer;

   assign starved  = (starve_cnt == CNT_MAX);
   assign starve_o = starved;

   // LSU wins contention unless EX has lost STARVE_LIMIT times in a row
   assign ex_ready_o  = rst & ex_valid_i & (~lsu_valid_i | starved);
   assign lsu_ready_o = rst & lsu_valid_i & ~(ex_valid_i & starved);
   assign any_xfer    = ex_ready_o | lsu_ready_o;

   always_comb begin
      win_addr = lsu_waddr_i;
      win_data = lsu_wdata_i;
      if (ex_ready_o) begin
         win_addr = ex_waddr_i;
         win_data = ex_wdata_i;
      end
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         starve_cnt  <= '0;
         reg_wen_o   <= 1'b0;
         reg_waddr_o <= '0;
         reg_wdata_o <= '0;
      end else begin
         if (ex_valid_i && lsu_ready_o)
            starve_cnt <= starved ? starve_cnt : starve_cnt + 1'b1;
         else
            starve_cnt <= '0;

         // x0 writes are consumed but never reach the register file
         if (any_xfer) begin
            reg_wen_o   <= |win_addr;
            reg_waddr_o <= win_addr;
            reg_wdata_o <= (|win_addr) ? win_data : 32'd0;
         end else begin
            reg_wen_o   <= 1'b0;
         end
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_regs_wb_arbiter.sv
`default_nettype none
// Directed and randomized self-checking bench for regs_wb_arbiter.
module tb_regs_wb_arbiter;

   localparam int LIMIT = 3;

   logic        clk = 1'b0;
   logic        rst;
   logic        ex_valid, lsu_valid;
   logic [4:0]  ex_waddr, lsu_waddr;
   logic [31:0] ex_wdata, lsu_wdata;
   logic        ex_ready, lsu_ready;
   logic [4:0]  reg_waddr;
   logic [31:0] reg_wdata;
   logic        reg_wen, starve;

   int checks = 0;
   int errors = 0;

   regs_wb_arbiter #(.STARVE_LIMIT(LIMIT)) dut (
      .clk         (clk),
      .rst         (rst),
      .ex_valid_i  (ex_valid),
      .ex_waddr_i  (ex_waddr),
      .ex_wdata_i  (ex_wdata),
      .ex_ready_o  (ex_ready),
      .lsu_valid_i (lsu_valid),
      .lsu_waddr_i (lsu_waddr),
      .lsu_wdata_i (lsu_wdata),
      .lsu_ready_o (lsu_ready),
      .reg_waddr_o (reg_waddr),
      .reg_wdata_o (reg_wdata),
      .reg_wen_o   (reg_wen),
      .starve_o    (starve)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic check_port(input string tag, input logic wen, input logic [4:0] a,
                             input logic [31:0] d);
      check({tag, "_wen"},   {31'd0, reg_wen}, {31'd0, wen});
      check({tag, "_waddr"}, {27'd0, reg_waddr}, {27'd0, a});
      check({tag, "_wdata"}, reg_wdata, d);
   endtask

   task automatic check_ready(input string tag, input logic exr, input logic lsr);
      #1;
      check({tag, "_ex_ready"},  {31'd0, ex_ready},  {31'd0, exr});
      check({tag, "_lsu_ready"}, {31'd0, lsu_ready}, {31'd0, lsr});
   endtask

   initial begin
      int          m_cnt;
      logic        e_ex, e_lsu, e_wen;
      logic [4:0]  e_addr;
      logic [31:0] e_data;

      rst = 1'b0;
      ex_valid = 1'b0; ex_waddr = '0; ex_wdata = '0;
      lsu_valid = 1'b0; lsu_waddr = '0; lsu_wdata = '0;
      tick();
      tick();

      // reset state, and no grants while reset is held
      check_port("reset", 1'b0, 5'd0, 32'd0);
      check("reset_starve", {31'd0, starve}, 32'd0);
      ex_valid = 1'b1; lsu_valid = 1'b1;
      check_ready("in_reset", 1'b0, 1'b0);
      ex_valid = 1'b0; lsu_valid = 1'b0;
      rst = 1'b1;
      tick();

      // EX only
      ex_valid = 1'b1; ex_waddr = 5'd5; ex_wdata = 32'h1234;
      check_ready("ex_only", 1'b1, 1'b0);
      tick();
      ex_valid = 1'b0;
      check_port("ex_only", 1'b1, 5'd5, 32'h1234);
      tick();
      check_port("idle_hold", 1'b0, 5'd5, 32'h1234);

      // contention: LSU wins three times, then EX is forced through
      ex_valid = 1'b1; ex_waddr = 5'd3; ex_wdata = 32'hAAAA_0003;
      lsu_valid = 1'b1; lsu_waddr = 5'd4;
      for (int i = 0; i < 3; i++) begin
         lsu_wdata = 32'h100 + i;
         check_ready("contend_lsu", 1'b0, 1'b1);
         check("contend_starve_lo", {31'd0, starve}, 32'd0);
         tick();
         check_port("contend_lsu", 1'b1, 5'd4, 32'h100 + i);
      end
      lsu_wdata = 32'h200;
      check_ready("contend_ex", 1'b1, 1'b0);
      check("contend_starve_hi", {31'd0, starve}, 32'd1);
      tick();
      check_port("contend_ex", 1'b1, 5'd3, 32'hAAAA_0003);
      ex_valid = 1'b0;
      check("starve_cleared", {31'd0, starve}, 32'd0);
      check_ready("lsu_after_starve", 1'b0, 1'b1);
      tick();
      check_port("lsu_after_starve", 1'b1, 5'd4, 32'h200);
      lsu_valid = 1'b0;

      // same destination: grant order decides the later write
      ex_valid = 1'b1; ex_waddr = 5'd7; ex_wdata = 32'hE;
      lsu_valid = 1'b1; lsu_waddr = 5'd7; lsu_wdata = 32'h1;
      check_ready("same_reg_1", 1'b0, 1'b1);
      tick();
      check_port("same_reg_1", 1'b1, 5'd7, 32'h1);
      lsu_valid = 1'b0;
      check_ready("same_reg_2", 1'b1, 1'b0);
      tick();
      check_port("same_reg_2", 1'b1, 5'd7, 32'hE);
      ex_valid = 1'b0;

      // write to x0 is accepted but suppressed
      lsu_valid = 1'b1; lsu_waddr = 5'd0; lsu_wdata = 32'hFFFF_FFFF;
      check_ready("x0", 1'b0, 1'b1);
      tick();
      check_port("x0", 1'b0, 5'd0, 32'd0);

      // streaming, one write per cycle
      for (int i = 0; i < 8; i++) begin
         lsu_waddr = 5'(i + 1); lsu_wdata = 32'hC0DE_0000 + i;
         check_ready("stream", 1'b0, 1'b1);
         tick();
         check_port("stream", 1'b1, 5'(i + 1), 32'hC0DE_0000 + i);
      end
      lsu_valid = 1'b0;
      tick();
      check_port("stream_end", 1'b0, 5'd8, 32'hC0DE_0007);

      // reset in the middle of contention
      ex_valid = 1'b1; ex_waddr = 5'd9; ex_wdata = 32'h99;
      lsu_valid = 1'b1; lsu_waddr = 5'd10; lsu_wdata = 32'hA0;
      tick();
      tick();
      rst = 1'b0;
      check_ready("mid_reset", 1'b0, 1'b0);
      tick();
      check_port("mid_reset", 1'b0, 5'd0, 32'd0);
      check("mid_reset_starve", {31'd0, starve}, 32'd0);
      rst = 1'b1;
      check_ready("post_reset_1", 1'b0, 1'b1);
      tick();
      check_port("post_reset_1", 1'b1, 5'd10, 32'hA0);
      check_ready("post_reset_2", 1'b0, 1'b1);
      tick();
      check_ready("post_reset_3", 1'b0, 1'b1);
      tick();
      check("post_reset_starve", {31'd0, starve}, 32'd1);
      check_ready("post_reset_ex", 1'b1, 1'b0);
      ex_valid = 1'b0; lsu_valid = 1'b0;
      tick();

      // random traffic against an independent arbitration model
      m_cnt = 0;
      e_addr = reg_waddr; e_data = reg_wdata;
      for (int c = 0; c < 3000; c++) begin
         if (!ex_valid || ex_ready) begin
            ex_valid = 1'($urandom_range(0, 1));
            ex_waddr = 5'($urandom_range(0, 31));
            ex_wdata = $urandom;
         end
         if (!lsu_valid || lsu_ready) begin
            lsu_valid = 1'($urandom_range(0, 1));
            lsu_waddr = 5'($urandom_range(0, 31));
            lsu_wdata = $urandom;
         end
         e_ex  = ex_valid && (!lsu_valid || m_cnt == LIMIT);
         e_lsu = lsu_valid && !(ex_valid && m_cnt == LIMIT);
         #1;
         check("rnd_mutex", {31'd0, ex_ready & lsu_ready}, 32'd0);
         check("rnd_ex_ready", {31'd0, ex_ready}, {31'd0, e_ex});
         check("rnd_lsu_ready", {31'd0, lsu_ready}, {31'd0, e_lsu});
         e_wen = 1'b0;
         if (e_ex || e_lsu) begin
            e_addr = e_ex ? ex_waddr : lsu_waddr;
            e_data = (e_addr == 5'd0) ? 32'd0 : (e_ex ? ex_wdata : lsu_wdata);
            e_wen  = (e_addr != 5'd0);
         end
         if (ex_valid && e_lsu) m_cnt = (m_cnt < LIMIT) ? m_cnt + 1 : m_cnt;
         else                   m_cnt = 0;
         @(posedge clk);
         #1;
         check_port("rnd", e_wen, e_addr, e_data);
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
`default_nettype wire
